vga_timing_gen: RTL

// - Parametrised VGA/LCD raster timing generator; successor to the fixed 640x480 controller.
// - Any mode via parameters, selectable sync polarity and an internal pixel-clock divider.
// - Registered, mutually aligned sync/blank/coordinate outputs plus line/frame strobes.
// - Feeds the slot-machine pixel pipeline and the frame-synchronous reel-animation logic.

---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/vga_timing_gen_if.sv | 30 +++
 rtl/vga_axis_counter.sv | 65 ++++++
 rtl/vga_timing_gen.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing descriptors and helpers for the parametrised raster generator.
package vga_timing_pkg;

  typedef struct packed {
    int h_disp;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_disp;
    int v_fp;
    int v_sync;
    int v_bp;
  } vga_timing_t;

  localparam vga_timing_t VGA_640x480_60 = '{
    h_disp: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_disp: 480, v_fp: 10, v_sync: 2,  v_bp: 33
  };

  localparam vga_timing_t LCD_1024x600 = '{
    h_disp: 1024, h_fp: 160, h_sync: 20, h_bp: 140,
    v_disp: 600,  v_fp: 12,  v_sync: 3,  v_bp: 20
  };

  function automatic int total(input int disp, input int fp, input int sync, input int bp);
    return disp + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle: the generator drives it, pixel/animation logic consumes it.
interface vga_timing_gen_if #(
  parameter int HW     = 10,
  parameter int VW     = 10,
  parameter int FCNT_W = 8
);

  logic              pix_tick;
  logic [HW-1:0]     hcount;
  logic [VW-1:0]     vcount;
  logic              hsync;
  logic              vsync;
  logic              active_video;
  logic [HW-1:0]     pix_x;
  logic [VW-1:0]     pix_y;
  logic              line_start;
  logic              frame_start;
  logic [FCNT_W-1:0] frame_count;

  modport master (
    output pix_tick, hcount, vcount, hsync, vsync, active_video,
           pix_x, pix_y, line_start, frame_start, frame_count
  );

  modport slave (
    input  pix_tick, hcount, vcount, hsync, vsync, active_video,
           pix_x, pix_y, line_start, frame_start, frame_count
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus decode of the value it will hold after this clk.
module vga_axis_counter #(
  parameter  int TOTAL = 800,
  parameter  int SYNC  = 96,
  parameter  int BACK  = 48,
  parameter  int DISP  = 640,
  localparam int CW    = $clog2(TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          sync_next,
  output logic          active_next,
  output logic [CW-1:0] coord_next
);

  localparam int            A0      = SYNC + BACK;
  localparam int            A1      = A0 + DISP;
  localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
  localparam logic [CW-1:0] A0_C    = CW'(A0);
  localparam logic [CW:0]   SYNC_LM = (CW+1)'(SYNC);
  localparam logic [CW:0]   A0_LM   = (CW+1)'(A0);
  localparam logic [CW:0]   A1_LM   = (CW+1)'(A1);

  logic [CW-1:0] count_nx;
  logic          lo_ok;
  logic          hi_ok;

  assign wrap = inc && (count == LAST);

  always_comb begin
    count_nx = count;
    if (inc) begin
      count_nx = wrap ? '0 : count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_nx;
    end
  end

  // stage p0: decode of the upcoming position, registered by the parent alongside count
  if (SYNC == 0) begin : g_no_sync
    assign sync_next = 1'b0;
  end else begin : g_sync
    assign sync_next = ({1'b0, count_nx} < SYNC_LM);
  end

  if (A0 == 0) begin : g_lo_open
    assign lo_ok = 1'b1;
  end else begin : g_lo_cmp
    assign lo_ok = ({1'b0, count_nx} >= A0_LM);
  end

  assign hi_ok       = ({1'b0, count_nx} < A1_LM);
  assign active_next = lo_ok && hi_ok;
  assign coord_next  = active_next ? (count_nx - A0_C) : '0;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: prescaler, two axis counters, aligned output registers.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter  int H_DISPLAY    = 640,
  parameter  int H_FRONT      = 16,
  parameter  int H_SYNC       = 96,
  parameter  int H_BACK       = 48,
  parameter  int V_DISPLAY    = 480,
  parameter  int V_FRONT      = 10,
  parameter  int V_SYNC       = 2,
  parameter  int V_BACK       = 33,
  parameter  int HSYNC_ACT_HI = 0,
  parameter  int VSYNC_ACT_HI = 0,
  parameter  int PIX_DIV      = 1,
  parameter  int FCNT_W       = 8,
  localparam int H_TOTAL      = total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK),
  localparam int V_TOTAL      = total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK),
  localparam int HW           = $clog2(H_TOTAL),
  localparam int VW           = $clog2(V_TOTAL)
) (
  input  logic             clk,
  input  logic             reset,
  vga_timing_gen_if.master vga
);

  localparam int            DW       = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic          HS_ON    = (HSYNC_ACT_HI != 0);
  localparam logic          VS_ON    = (VSYNC_ACT_HI != 0);

  logic [DW-1:0]     div_cnt;
  logic [DW-1:0]     div_nx;
  logic              tick_p0;
  logic              run;
  logic              h_inc;
  logic              h_wrap;
  logic              v_wrap;
  logic              h_sync_p0;
  logic              v_sync_p0;
  logic              h_act_p0;
  logic              v_act_p0;
  logic [HW-1:0]     h_coord_p0;
  logic [VW-1:0]     v_coord_p0;

  logic [HW-1:0]     hcount_p1;
  logic [VW-1:0]     vcount_p1;
  logic              vld_p1;
  logic              hsync_p1;
  logic              vsync_p1;
  logic              active_p1;
  logic [HW-1:0]     pix_x_p1;
  logic [VW-1:0]     pix_y_p1;
  logic              line_start_p1;
  logic              frame_start_p1;
  logic [FCNT_W-1:0] frame_count_p1;

  assign div_nx  = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
  assign tick_p0 = (div_nx == DIV_LAST);

  // The first tick after reset presents (0,0) instead of advancing past it.
  assign h_inc = tick_p0 && run;

  vga_axis_counter #(
    .TOTAL (H_TOTAL),
    .SYNC  (H_SYNC),
    .BACK  (H_BACK),
    .DISP  (H_DISPLAY)
  ) u_h (
    .clk         (clk),
    .reset       (reset),
    .inc         (h_inc),
    .count       (hcount_p1),
    .wrap        (h_wrap),
    .sync_next   (h_sync_p0),
    .active_next (h_act_p0),
    .coord_next  (h_coord_p0)
  );

  vga_axis_counter #(
    .TOTAL (V_TOTAL),
    .SYNC  (V_SYNC),
    .BACK  (V_BACK),
    .DISP  (V_DISPLAY)
  ) u_v (
    .clk         (clk),
    .reset       (reset),
    .inc         (h_wrap),
    .count       (vcount_p1),
    .wrap        (v_wrap),
    .sync_next   (v_sync_p0),
    .active_next (v_act_p0),
    .coord_next  (v_coord_p0)
  );

  // stage p1: outputs registered on the same edge the counters move
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt        <= '0;
      run            <= 1'b0;
      vld_p1         <= 1'b0;
      hsync_p1       <= ~HS_ON;
      vsync_p1       <= ~VS_ON;
      active_p1      <= 1'b0;
      pix_x_p1       <= '0;
      pix_y_p1       <= '0;
      line_start_p1  <= 1'b0;
      frame_start_p1 <= 1'b0;
      frame_count_p1 <= '0;
    end else begin
      div_cnt        <= div_nx;
      vld_p1         <= tick_p0;
      line_start_p1  <= h_wrap;
      frame_start_p1 <= h_wrap && v_wrap;
      if (h_wrap && v_wrap) begin
        frame_count_p1 <= frame_count_p1 + 1'b1;
      end
      if (tick_p0) begin
        run       <= 1'b1;
        hsync_p1  <= h_sync_p0 ? HS_ON : ~HS_ON;
        vsync_p1  <= v_sync_p0 ? VS_ON : ~VS_ON;
        active_p1 <= h_act_p0 && v_act_p0;
        pix_x_p1  <= (h_act_p0 && v_act_p0) ? h_coord_p0 : '0;
        pix_y_p1  <= (h_act_p0 && v_act_p0) ? v_coord_p0 : '0;
      end
    end
  end

  assign vga.pix_tick     = vld_p1;
  assign vga.hcount       = hcount_p1;
  assign vga.vcount       = vcount_p1;
  assign vga.hsync        = hsync_p1;
  assign vga.vsync        = vsync_p1;
  assign vga.active_video = active_p1;
  assign vga.pix_x        = pix_x_p1;
  assign vga.pix_y        = pix_y_p1;
  assign vga.line_start   = line_start_p1;
  assign vga.frame_start  = frame_start_p1;
  assign vga.frame_count  = frame_count_p1;

endmodule
